// File: rtl/mac_pe_sequenced.sv
// rtl/mac_pe_sequenced.sv - systolic MAC processing element with built-in accumulation-window sequencer
// Optional build macro: MAC_SATURATE_EN (saturating product and accumulation instead of modulo wrap).
module mac_pe_sequenced #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_LEN    = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] A_in,
   input  logic [DATA_WIDTH-1:0] B_in,
   output logic [DATA_WIDTH-1:0] A_out,
   output logic [DATA_WIDTH-1:0] B_out,
   output logic [DATA_WIDTH-1:0] C_out,
   output logic                  load_out
);

   // A one-product window still needs a 1-bit counter register.
   localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0] sum;

   // Window strobe comes purely from the counter so neighbours can share it.
   assign load_out = (cnt == CNT_LAST);

`ifdef MAC_SATURATE_EN
   logic [2*DATA_WIDTH-1:0] prod_full;
   logic [DATA_WIDTH:0]     sum_ext;

   // Saturating product and accumulate: any overflow clamps to all-ones.
   always_comb begin
      prod_full = {{DATA_WIDTH{1'b0}}, A_in} * {{DATA_WIDTH{1'b0}}, B_in};
      prod      = (|prod_full[2*DATA_WIDTH-1:DATA_WIDTH]) ? '1 : prod_full[DATA_WIDTH-1:0];
      sum_ext   = {1'b0, acc} + {1'b0, prod};
      sum       = sum_ext[DATA_WIDTH] ? '1 : sum_ext[DATA_WIDTH-1:0];
   end
`else
   // Modulo product and accumulate: results simply truncate to DATA_WIDTH.
   always_comb begin
      prod = A_in * B_in;
      sum  = acc + prod;
   end
`endif

   // Window counter: free-running, wraps after the last product of the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load_out) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Accumulate every cycle; on the window end publish the sum including this product and clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         C_out <= '0;
      end else if (load_out) begin
         acc   <= '0;
         C_out <= sum;
      end else begin
         acc   <= sum;
      end
   end

   // Operand forwarding to the right and downward neighbours, one cycle late.
   always_ff @(posedge clk) begin
      if (rst) begin
         A_out <= '0;
         B_out <= '0;
      end else begin
         A_out <= A_in;
         B_out <= B_in;
      end
   end

endmodule

// File: tb/tb_mac_pe_sequenced.sv
// tb/tb_mac_pe_sequenced.sv - self-checking bench for mac_pe_sequenced against a window-sum reference model
module tb_mac_pe_sequenced;

   localparam int DW = 32;
   localparam int L  = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [DW-1:0] a_in, b_in, a_out, b_out, c_out;
   logic          load_out;

   logic          rst1;
   logic [DW-1:0] a1_in, b1_in, a1_out, b1_out, c1_out;
   logic          load1_out;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state: edges since reset, products of the open window, expected outputs
   int            n;
   logic [DW-1:0] win_q[$];
   logic [DW-1:0] exp_a, exp_b, exp_c;

   mac_pe_sequenced #(.DATA_WIDTH(DW), .ACC_LEN(L)) dut (
      .clk(clk), .rst(rst), .A_in(a_in), .B_in(b_in),
      .A_out(a_out), .B_out(b_out), .C_out(c_out), .load_out(load_out)
   );

   mac_pe_sequenced #(.DATA_WIDTH(DW), .ACC_LEN(1)) dut1 (
      .clk(clk), .rst(rst1), .A_in(a1_in), .B_in(b1_in),
      .A_out(a1_out), .B_out(b1_out), .C_out(c1_out), .load_out(load1_out)
   );

   function automatic logic [DW-1:0] prod_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint unsigned full;
      full = longint'(a) * longint'(b);
`ifdef MAC_SATURATE_EN
      if (full > 64'(32'hFFFF_FFFF)) return '1;
`endif
      return full[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] window_total();
      longint unsigned total = 0;
      foreach (win_q[i]) total += longint'(win_q[i]);
`ifdef MAC_SATURATE_EN
      if (total > 64'(32'hFFFF_FFFF)) return '1;
`endif
      return total[DW-1:0];
   endfunction

   function automatic logic exp_load();
      return (n % L) == (L - 1);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0; win_q.delete();
      exp_a = '0; exp_b = '0; exp_c = '0;
   endtask

   task automatic clock_in(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic closing;
      a_in = a; b_in = b;
      closing = exp_load();
      @(posedge clk); #1;
      win_q.push_back(prod_ref(a, b));
      if (closing) begin
         exp_c = window_total();
         win_q.delete();
      end
      n++;
      exp_a = a; exp_b = b;
   endtask

   task automatic test_reset();
      a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0;
      do_reset();
      vectors++;
      if ({a_out, b_out, c_out, load_out} !== {exp_a, exp_b, exp_c, 1'b0}) begin
         miscompares++;
         $display("FAIL reset: A_out=%h B_out=%h C_out=%h load=%b, want all 0", a_out, b_out, c_out, load_out);
      end
   endtask

   task automatic test_constant();
      do_reset();
      for (int i = 0; i < 21; i++) begin
         clock_in(32'd2, 32'd3);
         vectors++;
         if (load_out !== exp_load() || c_out !== exp_c || a_out !== 32'd2 || b_out !== 32'd3) begin
            miscompares++;
            $display("FAIL constant n=%0d: load=%b C=%0d A=%0d B=%0d, want load=%b C=%0d A=2 B=3",
                     n, load_out, c_out, a_out, b_out, exp_load(), exp_c);
         end
         if (n == 6 || n == 13 || n == 20) begin
            vectors++;
            if (load_out !== 1'b1) begin
               miscompares++;
               $display("FAIL constant_load n=%0d: load=%b want 1", n, load_out);
            end
         end
      end
      vectors++;
      if (c_out !== 32'd42) begin
         miscompares++;
         $display("FAIL constant_sum: C_out=%0d want 42", c_out);
      end
   endtask

   task automatic test_ramp();
      do_reset();
      for (int i = 1; i <= 7; i++) clock_in(32'(i), 32'd1);
      vectors++;
      if (c_out !== 32'd28 || exp_c !== 32'd28) begin
         miscompares++;
         $display("FAIL ramp: C_out=%0d want 28", c_out);
      end
      for (int i = 0; i < 7; i++) clock_in(32'd0, 32'd0);
      vectors++;
      if (c_out !== 32'd0) begin
         miscompares++;
         $display("FAIL ramp_zero: C_out=%0d want 0", c_out);
      end
   endtask

   task automatic test_passthrough();
      logic [DW-1:0] seq_a[2];
      seq_a[0] = 32'd5; seq_a[1] = 32'd9;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         clock_in(seq_a[i], 32'hFFFF_FFFF);
         vectors++;
         if (a_out !== seq_a[i] || b_out !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL passthrough %0d: A_out=%h B_out=%h want %h FFFFFFFF", i, a_out, b_out, seq_a[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] want;
`ifdef MAC_SATURATE_EN
      want = 32'hFFFF_FFFF;
`else
      want = 32'h0;
`endif
      do_reset();
      for (int i = 0; i < 7; i++) clock_in(32'h0001_0000, 32'h0001_0000);
      vectors++;
      if (c_out !== want || load_out !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap: C_out=%h load=%b want %h load=0", c_out, load_out, want);
      end
   endtask

   task automatic test_reset_mid_window();
      do_reset();
      for (int i = 0; i < 3; i++) clock_in(32'd1, 32'd1);
      do_reset();
      vectors++;
      if (c_out !== 32'd0 || load_out !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_clear: C_out=%0d load=%b want 0 0", c_out, load_out);
      end
      for (int i = 0; i < 7; i++) begin
         clock_in(32'd1, 32'd1);
         vectors++;
         if (load_out !== (n == 6) || c_out !== exp_c) begin
            miscompares++;
            $display("FAIL midreset n=%0d: load=%b C=%0d want load=%b C=%0d", n, load_out, c_out, n == 6, exp_c);
         end
      end
      vectors++;
      if (c_out !== 32'd7) begin
         miscompares++;
         $display("FAIL midreset_sum: C_out=%0d want 7", c_out);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] a, b;
      do_reset();
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         case ($urandom_range(0, 2))
            0:       begin a = $urandom; b = $urandom; end
            1:       begin a = $urandom_range(0, 300); b = $urandom_range(0, 300); end
            default: begin a = $urandom; b = $urandom_range(0, 3); end
         endcase
         clock_in(a, b);
         vectors++;
         if ({a_out, b_out, c_out, load_out} !== {exp_a, exp_b, exp_c, exp_load()}) begin
            miscompares++;
            $display("FAIL random n=%0d: A=%h B=%h C=%h load=%b want A=%h B=%h C=%h load=%b",
                     n, a_out, b_out, c_out, load_out, exp_a, exp_b, exp_c, exp_load());
         end
      end
   endtask

   task automatic test_acc_len_one();
      logic [DW-1:0] a, b;
      rst1 = 1'b1; a1_in = '0; b1_in = '0;
      @(posedge clk); #1;
      rst1 = 1'b0;
      vectors++;
      if (c1_out !== 32'd0 || load1_out !== 1'b1) begin
         miscompares++;
         $display("FAIL len1_reset: C_out=%0d load=%b want 0 1", c1_out, load1_out);
      end
      a1_in = 32'd4; b1_in = 32'd5;
      @(posedge clk); #1;
      vectors++;
      if (c1_out !== 32'd20 || load1_out !== 1'b1) begin
         miscompares++;
         $display("FAIL len1_20: C_out=%0d load=%b want 20 1", c1_out, load1_out);
      end
      a1_in = 32'd6; b1_in = 32'd6;
      @(posedge clk); #1;
      vectors++;
      if (c1_out !== 32'd36 || load1_out !== 1'b1) begin
         miscompares++;
         $display("FAIL len1_36: C_out=%0d load=%b want 36 1", c1_out, load1_out);
      end
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom_range(0, 1000);
         a1_in = a; b1_in = b;
         @(posedge clk); #1;
         vectors++;
         if (c1_out !== prod_ref(a, b) || load1_out !== 1'b1 || a1_out !== a) begin
            miscompares++;
            $display("FAIL len1_random: C_out=%h load=%b A_out=%h want %h 1 %h",
                     c1_out, load1_out, a1_out, prod_ref(a, b), a);
         end
      end
   endtask

   initial begin
      rst = 1'b1; a_in = '0; b_in = '0;
      rst1 = 1'b1; a1_in = '0; b1_in = '0;
      n = 0; exp_a = '0; exp_b = '0; exp_c = '0;
      @(posedge clk); #1;
      test_reset();
      test_constant();
      test_ramp();
      test_passthrough();
      test_wrap();
      test_reset_mid_window();
      test_random();
      test_acc_len_one();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mac_pe_sequenced.md
Name: mac_pe_sequenced

Overview:
- Single systolic-array processing element with its own accumulation-window sequencer.
- Multiplies the streaming operands A and B, accumulates the products over a fixed window, then publishes the sum on C_out and clears the accumulator.
- Forwards A to the right-hand neighbour and B to the neighbour below, one cycle later.
- Exports the window strobe so the array top can observe or share it. Arrays tile N×M instances.

Parameters:
- DATA_WIDTH, 32, width of A, B, C and the accumulator.
- ACC_LEN, 7, products per accumulation window (3N-2 for a 3×3 array); legal range is ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- A_in  input  DATA_WIDTH  row operand from the left neighbour or the array edge.
- B_in  input  DATA_WIDTH  column operand from the neighbour above or the array edge.
- A_out  output  DATA_WIDTH  registered copy of A_in.
- B_out  output  DATA_WIDTH  registered copy of B_in.
- C_out  output  DATA_WIDTH  result of the most recently completed window.
- load_out  output  1  window-end strobe.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) forces the following to 0: A_out, B_out, C_out, accumulator acc, window counter cnt. load_out is 0 while cnt≠ACC_LEN-1. rst has priority over all other actions.
- Sequencer:
  - cnt has width clog2(ACC_LEN), minimum 1 bit.
  - cnt increments each edge and wraps from ACC_LEN-1 to 0.
  - load_out = (cnt == ACC_LEN-1), decoded from the register only; no dependence on data inputs.
  - The first load_out pulse follows ACC_LEN-1 edges after reset release, then recurs every ACC_LEN cycles as a one-cycle pulse.
  - ACC_LEN=1: load_out is held high continuously after reset.
- Forwarding: A_out <= A_in and B_out <= B_in every edge, latency 1. This is independent of load_out.
- Arithmetic:
  - prod = A_in * B_in, unsigned, truncated to DATA_WIDTH LSBs.
  - Accumulation wraps modulo 2^DATA_WIDTH (default build).
- Per edge, when rst=0:
  - load_out=0: acc <= acc + prod; C_out holds its value.
  - load_out=1: C_out <= acc + prod, so the final product is included; acc <= 0.
  - Each window therefore sums exactly ACC_LEN consecutive products.
- C_out changes only on the load edge (or reset) and holds until the next window completes.
- Reset mid-window discards the partial sum, and the next window restarts at full length.
- No handshake: operands are consumed every cycle, and zero operands contribute 0.

Optional Feature:
- Macro MAC_SATURATE_EN.
- Defined:
  - Each accumulator add saturates at 2^DATA_WIDTH-1 instead of wrapping.
  - The product itself saturates rather than truncates when the full 2×DATA_WIDTH result exceeds the maximum.
  - The C_out load path uses the same saturating sum.
  - A saturated accumulator stays at maximum until cleared by the load or rst.
- Undefined: pure modulo arithmetic as above. No extra ports in either build.

Test Plan:
- Reset then constant A_in=2, B_in=3, ACC_LEN=7 -> load_out high on cycles 6, 13, 20 after release; C_out=42 after the 7th edge and stays 42 across later windows; A_out=2, B_out=3 from edge 1.
- Ramp A_in=1..7, B_in=1 over the first window -> C_out=28; the next window with A_in=B_in=0 -> C_out=0.
- Pass-through A_in=5 then 9, B_in=0xFFFFFFFF -> A_out=5 then 9 and B_out=0xFFFFFFFF, each one edge later.
- Wrap: A_in=B_in=0x00010000 all window -> C_out=0; with MAC_SATURATE_EN -> C_out=0xFFFFFFFF.
- Reset mid-window: A=B=1, rst pulsed at cycle 3 -> acc, cnt, C_out=0; next load_out at cycle 6 after release, with C_out=7.
- ACC_LEN=1, A_in=4, B_in=5 -> load_out constantly 1; C_out=20 one edge after the inputs; inputs changed to 6,6 -> C_out=36 next edge.
